// File: rtl/cory_demux2.sv
// Two-way tag-routed demux with a private D-entry FIFO per output. Data is
// visible one cycle after acceptance. Input ready depends only on the tagged FIFO's registered fill level.

module cory_demux2_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         full,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  localparam int CW = $clog2(D + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [D];
  logic [W-1:0]  mem_d [D];
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(D));
  assign out_vld = (count_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign push_ok = push_vld & ~full;
  assign pop_ok  = out_vld & pop_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

module cory_demux2 #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  input  logic         i_a_s,
  output logic         o_a_r,
  output logic         o_z0_v,
  output logic [N-1:0] o_z0_d,
  input  logic         i_z0_r,
  output logic         o_z1_v,
  output logic [N-1:0] o_z1_d,
  input  logic         i_z1_r
);

  logic full0;
  logic full1;
  logic acc;
  logic push0_vld;
  logic push1_vld;

  // A full FIFO never passes its consumer's ready back to the input.
  assign o_a_r     = i_a_s ? ~full1 : ~full0;
  assign acc       = i_a_v & o_a_r;
  assign push0_vld = acc & ~i_a_s;
  assign push1_vld = acc & i_a_s;

  cory_demux2_fifo #(.W(N), .D(D)) u_fifo0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (push0_vld),
    .push_dat (i_a_d),
    .pop_rdy  (i_z0_r),
    .full     (full0),
    .out_vld  (o_z0_v),
    .out_dat  (o_z0_d)
  );

  cory_demux2_fifo #(.W(N), .D(D)) u_fifo1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (push1_vld),
    .push_dat (i_a_d),
    .pop_rdy  (i_z1_r),
    .full     (full1),
    .out_vld  (o_z1_v),
    .out_dat  (o_z1_d)
  );

endmodule

// File: tb/tb_cory_demux2.sv
// Randomised and directed bench for cory_demux2 with a queue-based reference model.
module tb_cory_demux2;
  localparam int N = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_a_v = 1'b0;
  logic [N-1:0] i_a_d = '0;
  logic         i_a_s = 1'b0;
  logic         o_a_r;
  logic         o_z0_v;
  logic [N-1:0] o_z0_d;
  logic         i_z0_r = 1'b0;
  logic         o_z1_v;
  logic [N-1:0] o_z1_d;
  logic         i_z1_r = 1'b0;

  always #5 clk = ~clk;

  cory_demux2 #(.N(N), .D(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_a_v   (i_a_v),
    .i_a_d   (i_a_d),
    .i_a_s   (i_a_s),
    .o_a_r   (o_a_r),
    .o_z0_v  (o_z0_v),
    .o_z0_d  (o_z0_d),
    .i_z0_r  (i_z0_r),
    .o_z1_v  (o_z1_v),
    .o_z1_d  (o_z1_d),
    .i_z1_r  (i_z1_r)
  );

  // Reference model: per-output queues of accepted items, capacity D each.
  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];
  int           errors = 0;
  int           checks = 0;
  logic         exp_rdy = 1'b1;
  logic         acc_vld = 1'b0;
  logic         acc_tag = 1'b0;
  logic [N-1:0] acc_dat = '0;
  logic         do_final = 1'b0;
  logic         fin_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Capture side: record what the model says was transferred at this edge.
  always @(posedge clk) begin
    acc_vld <= reset_n && i_a_v && exp_rdy;
    acc_tag <= i_a_s;
    acc_dat <= i_a_d;
  end

  // Monitor: apply last edge's acceptance, then check and pop for the next edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      exp_rdy = 1'b1;
      check("rst_z0_v", {31'd0, o_z0_v}, 32'd0);
      check("rst_z1_v", {31'd0, o_z1_v}, 32'd0);
      check("rst_a_r", {31'd0, o_a_r}, 32'd1);
    end else begin
      if (acc_vld) begin
        if (acc_tag) q1.push_back(acc_dat);
        else         q0.push_back(acc_dat);
      end
      exp_rdy = i_a_s ? (q1.size() < D) : (q0.size() < D);
      check("a_r", {31'd0, o_a_r}, {31'd0, exp_rdy});
      check("z0_v", {31'd0, o_z0_v}, {31'd0, q0.size() != 0});
      check("z1_v", {31'd0, o_z1_v}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) begin
        check("z0_d", {24'd0, o_z0_d}, {24'd0, q0[0]});
        if (i_z0_r) void'(q0.pop_front());
      end
      if (q1.size() != 0) begin
        check("z1_d", {24'd0, o_z1_d}, {24'd0, q1[0]});
        if (i_z1_r) void'(q1.pop_front());
      end
      if (do_final && !fin_done) begin
        check("drain_q0", q0.size(), 32'd0);
        check("drain_q1", q1.size(), 32'd0);
        fin_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) step();
    reset_n = 1'b1;

    // Single item to z0.
    i_z0_r = 1'b1; i_z1_r = 1'b1;
    i_a_v = 1'b1; i_a_s = 1'b0; i_a_d = 8'h11;
    step();
    i_a_v = 1'b0;
    repeat (2) step();

    // Fill z0 while stalled, offer a third tag-0 item, then route to z1.
    i_z0_r = 1'b0;
    i_a_v = 1'b1; i_a_s = 1'b0; i_a_d = 8'hA0; step();
    i_a_d = 8'hA1; step();
    i_a_d = 8'hA2; step();
    i_a_s = 1'b1; i_a_d = 8'hB0; step();
    i_a_v = 1'b0; step();

    // Full FIFO popping this cycle must not accept until the next cycle.
    i_a_v = 1'b1; i_a_s = 1'b0; i_a_d = 8'hA2; i_z0_r = 1'b1;
    step();
    step();
    i_a_v = 1'b0;
    repeat (3) step();

    // Alternating tags at full rate.
    for (int i = 0; i < 4; i++) begin
      i_a_v = 1'b1; i_a_s = i[0]; i_a_d = N'(i + 1);
      step();
    end
    i_a_v = 1'b0;
    repeat (3) step();

    // Load both FIFOs, reset mid-operation, then send fresh items.
    i_z0_r = 1'b0; i_z1_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_a_v = 1'b1; i_a_s = i[0]; i_a_d = N'(8'hC0 + i);
      step();
    end
    i_a_v = 1'b0;
    step();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    i_z0_r = 1'b1; i_z1_r = 1'b1;
    i_a_v = 1'b1; i_a_s = 1'b0; i_a_d = 8'hD0; step();
    i_a_s = 1'b1; i_a_d = 8'hD1; step();
    i_a_v = 1'b0;
    repeat (3) step();

    // Random traffic with phases that stall one output at a time.
    for (int c = 0; c < 10000; c++) begin
      int ph;
      ph = (c / 256) % 4;
      if (!(i_a_v && !acc_vld)) begin
        i_a_v = ($urandom_range(0, 3) != 0);
        i_a_s = 1'($urandom_range(0, 1));
        i_a_d = N'($urandom);
      end
      i_z0_r = (ph == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      i_z1_r = (ph == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if (ph == 3) begin
        i_z0_r = 1'b1;
        i_z1_r = 1'b1;
      end
      step();
    end

    i_a_v = 1'b0; i_z0_r = 1'b1; i_z1_r = 1'b1;
    repeat (10) step();
    do_final = 1'b1;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
